pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 100 ++++++++++
 tb/tb_pipe_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: ID decode plus ID/EX/MEM/WB control pipeline with load-use stall and forwarding select.
// Optional ILLEGAL_TRAP_EN builds an EX illegal-opcode flag driving o_illegal.
module pipe_ctrl #(
   parameter int ALUOP_W = 4,
   parameter int REG_W = 5,
   localparam int CTRL_W = ALUOP_W + 7
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [31:0]       i_instr,
   input  logic              i_valid,
   input  logic              i_flush,
   input  logic              i_mem_stall,
   output logic [CTRL_W-1:0] o_ex_ctrl,
   output logic [CTRL_W-1:0] o_mem_ctrl,
   output logic [CTRL_W-1:0] o_wb_ctrl,
   output logic              o_ex_valid,
   output logic              o_mem_valid,
   output logic              o_wb_valid,
   output logic [REG_W-1:0]  o_ex_rd,
   output logic [REG_W-1:0]  o_mem_rd,
   output logic [REG_W-1:0]  o_wb_rd,
   output logic [1:0]        o_fwd_a,
   output logic [1:0]        o_fwd_b,
   output logic              o_stall,
   output logic              o_illegal
);
   // bundle = {alu_op, exec_a, exec_b, mem_w, reg_w, mem2reg, bra, jmp}
   localparam logic [CTRL_W-1:0] R_CTRL       = {ALUOP_W'(4'h2), 7'b0001000};
   localparam logic [CTRL_W-1:0] I_JUMP_CTRL  = {ALUOP_W'(4'h0), 7'b1101001};
   localparam logic [CTRL_W-1:0] I_LOAD_CTRL  = {ALUOP_W'(4'h0), 7'b0101100};
   localparam logic [CTRL_W-1:0] I_ARITH_CTRL = {ALUOP_W'(4'h3), 7'b0101000};
   localparam logic [CTRL_W-1:0] I_SYS_CTRL   = {ALUOP_W'(4'hF), 7'b0000000};
   localparam logic [CTRL_W-1:0] I_FENCE_CTRL = {ALUOP_W'(4'hE), 7'b0000000};
   localparam logic [CTRL_W-1:0] S_CTRL       = {ALUOP_W'(4'h0), 7'b0110000};
   localparam logic [CTRL_W-1:0] B_CTRL       = {ALUOP_W'(4'h1), 7'b0000010};
   localparam logic [CTRL_W-1:0] U_LUI_CTRL   = {ALUOP_W'(4'h4), 7'b0101000};
   localparam logic [CTRL_W-1:0] U_AUIPC_CTRL = {ALUOP_W'(4'h0), 7'b1101000};
   localparam logic [CTRL_W-1:0] J_CTRL       = {ALUOP_W'(4'h0), 7'b1101001};
   logic [CTRL_W-1:0] dec_ctrl;
   logic              known, use1, use2;
   logic [REG_W-1:0]  id_rs1, id_rs2, ex_rs1, ex_rs2;
   logic              mem_fw, wb_fw, bubble;
   logic              unused_funct;
   always_comb begin
      dec_ctrl = '0;
      known = 1'b1;
      use1 = 1'b0;
      use2 = 1'b0;
      case (i_instr[6:0])
         7'h33: begin dec_ctrl = R_CTRL; use1 = 1'b1; use2 = 1'b1; end
         7'h67: begin dec_ctrl = I_JUMP_CTRL; use1 = 1'b1; end
         7'h03: begin dec_ctrl = I_LOAD_CTRL; use1 = 1'b1; end
         7'h13: begin dec_ctrl = I_ARITH_CTRL; use1 = 1'b1; end
         7'h73: dec_ctrl = I_SYS_CTRL;
         7'h0F: dec_ctrl = I_FENCE_CTRL;
         7'h23: begin dec_ctrl = S_CTRL; use1 = 1'b1; use2 = 1'b1; end
         7'h63: begin dec_ctrl = B_CTRL; use1 = 1'b1; use2 = 1'b1; end
         7'h37: dec_ctrl = U_LUI_CTRL;
         7'h17: dec_ctrl = U_AUIPC_CTRL;
         7'h6F: dec_ctrl = J_CTRL;
         default: known = 1'b0;
      endcase
   end
   // unused source fields are stored as 0 so they can never match a destination
   assign id_rs1 = use1 ? i_instr[15 +: REG_W] : '0;
   assign id_rs2 = use2 ? i_instr[20 +: REG_W] : '0;
   assign unused_funct = ^{i_instr[31:25], i_instr[14:12]};
   assign o_stall = i_valid & o_ex_valid & o_ex_ctrl[2] & (o_ex_rd != '0) &
                    ((o_ex_rd == id_rs1) | (o_ex_rd == id_rs2));
   assign bubble = i_flush | o_stall | ~i_valid;
   assign mem_fw = o_mem_valid & o_mem_ctrl[3] & (o_mem_rd != '0);
   assign wb_fw = o_wb_valid & o_wb_ctrl[3] & (o_wb_rd != '0);
   assign o_fwd_a = (mem_fw && o_mem_rd == ex_rs1) ? 2'b10 : (wb_fw && o_wb_rd == ex_rs1) ? 2'b01 : 2'b00;
   assign o_fwd_b = (mem_fw && o_mem_rd == ex_rs2) ? 2'b10 : (wb_fw && o_wb_rd == ex_rs2) ? 2'b01 : 2'b00;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         {o_ex_valid, o_ex_ctrl, o_ex_rd, ex_rs1, ex_rs2} <= '0;
         {o_mem_valid, o_mem_ctrl, o_mem_rd} <= '0;
         {o_wb_valid, o_wb_ctrl, o_wb_rd} <= '0;
      end else if (!i_mem_stall) begin
         {o_wb_valid, o_wb_ctrl, o_wb_rd} <= {o_mem_valid, o_mem_ctrl, o_mem_rd};
         {o_mem_valid, o_mem_ctrl, o_mem_rd} <= {o_ex_valid, o_ex_ctrl, o_ex_rd};
         {o_ex_valid, o_ex_ctrl, o_ex_rd, ex_rs1, ex_rs2} <= bubble ? '0 :
            {1'b1, dec_ctrl, i_instr[7 +: REG_W], id_rs1, id_rs2};
      end
   end
`ifdef ILLEGAL_TRAP_EN
   logic ex_illegal;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) ex_illegal <= 1'b0;
      else if (!i_mem_stall) ex_illegal <= ~bubble & ~known;
   end
   assign o_illegal = ex_illegal;
`else
   logic unused_known;
   assign unused_known = known;
   assign o_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized and directed checks of pipe_ctrl against an instruction-level pipeline model.
module tb_pipe_ctrl;
   typedef struct packed { logic v; logic [31:0] ins; } rec_t;
   logic        clk = 1'b0, rst_n;
   logic [31:0] instr;
   logic        valid, flush, mstall;
   logic [10:0] ex_ctrl, mem_ctrl, wb_ctrl;
   logic        ex_valid, mem_valid, wb_valid, stall, illegal;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic [1:0]  fwd_a, fwd_b;
   rec_t        m_ex, m_mem, m_wb;
   int          n_chk = 0, n_fail = 0;
   localparam logic [31:0] ADD_3_1_2 = {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
   localparam logic [31:0] LW_5_1    = {12'd0, 5'd1, 3'd2, 5'd5, 7'h03};
   localparam logic [31:0] ADD_6_5_2 = {7'h00, 5'd2, 5'd5, 3'd0, 5'd6, 7'h33};
   localparam logic [31:0] ADD_5_1_2 = {7'h00, 5'd2, 5'd1, 3'd0, 5'd5, 7'h33};
   localparam logic [31:0] SUB_7_5_5 = {7'h20, 5'd5, 5'd5, 3'd0, 5'd7, 7'h33};
   localparam logic [31:0] ADD_0_1_2 = {7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33};
   localparam logic [31:0] SUB_7_0_0 = {7'h20, 5'd0, 5'd0, 3'd0, 5'd7, 7'h33};
   localparam logic [31:0] BEQ_1_2   = {7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63};
   localparam logic [31:0] BAD_OP    = {25'h0, 7'h7F};
   localparam logic [10:0] R_C = {4'h2, 7'b0001000};
   localparam logic [10:0] B_C = {4'h1, 7'b0000010};
   localparam logic [6:0]  OPS [12] = '{7'h33, 7'h67, 7'h03, 7'h13, 7'h73, 7'h0F,
                                       7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

   pipe_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_valid(valid), .i_flush(flush),
      .i_mem_stall(mstall), .o_ex_ctrl(ex_ctrl), .o_mem_ctrl(mem_ctrl), .o_wb_ctrl(wb_ctrl),
      .o_ex_valid(ex_valid), .o_mem_valid(mem_valid), .o_wb_valid(wb_valid),
      .o_ex_rd(ex_rd), .o_mem_rd(mem_rd), .o_wb_rd(wb_rd), .o_fwd_a(fwd_a), .o_fwd_b(fwd_b),
      .o_stall(stall), .o_illegal(illegal)
   );

   always #5 clk = ~clk;

   // opcode table: {alu_op, exec_a, exec_b, mem_w, reg_w, mem2reg, bra, jmp}
   function automatic logic [10:0] ctrl_of(input logic [6:0] op);
      case (op)
         7'h33: return {4'h2, 7'b0001000};
         7'h67: return {4'h0, 7'b1101001};
         7'h03: return {4'h0, 7'b0101100};
         7'h13: return {4'h3, 7'b0101000};
         7'h73: return {4'hF, 7'b0000000};
         7'h0F: return {4'hE, 7'b0000000};
         7'h23: return {4'h0, 7'b0110000};
         7'h63: return {4'h1, 7'b0000010};
         7'h37: return {4'h4, 7'b0101000};
         7'h17: return {4'h0, 7'b1101000};
         7'h6F: return {4'h0, 7'b1101001};
         default: return 11'h0;
      endcase
   endfunction
   function automatic bit known(input logic [6:0] op);
      return op inside {7'h33, 7'h67, 7'h03, 7'h13, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
   endfunction
   function automatic bit uses1(input logic [6:0] op);
      return op inside {7'h33, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63};
   endfunction
   function automatic bit uses2(input logic [6:0] op);
      return op inside {7'h33, 7'h23, 7'h63};
   endfunction
   function automatic bit writes(input rec_t r);
      return r.v && r.ins[6:0] inside {7'h33, 7'h67, 7'h03, 7'h13, 7'h37, 7'h17, 7'h6F} && r.ins[11:7] != 0;
   endfunction
   function automatic logic [16:0] stage_of(input rec_t r);
      return r.v ? {1'b1, ctrl_of(r.ins[6:0]), r.ins[11:7]} : 17'h0;
   endfunction
   function automatic bit exp_stall();
      logic [4:0] d = m_ex.ins[11:7];
      return valid && m_ex.v && m_ex.ins[6:0] == 7'h03 && d != 0 &&
             ((uses1(instr[6:0]) && instr[19:15] == d) || (uses2(instr[6:0]) && instr[24:20] == d));
   endfunction
   function automatic logic [1:0] exp_fwd(input bit second);
      logic [4:0] rs = second ? m_ex.ins[24:20] : m_ex.ins[19:15];
      if (!m_ex.v || !(second ? uses2(m_ex.ins[6:0]) : uses1(m_ex.ins[6:0]))) return 2'b00;
      if (writes(m_mem) && m_mem.ins[11:7] == rs) return 2'b10;
      if (writes(m_wb) && m_wb.ins[11:7] == rs) return 2'b01;
      return 2'b00;
   endfunction
   function automatic bit exp_ill();
`ifdef ILLEGAL_TRAP_EN
      return m_ex.v && !known(m_ex.ins[6:0]);
`else
      return 1'b0;
`endif
   endfunction

   // clock edge consumes the inputs held so far, then the next inputs are applied
   task automatic step(input logic [31:0] ins, input logic v, input logic f, input logic ms);
      rec_t nx;
      nx = (flush || exp_stall() || !valid) ? '0 : {1'b1, instr};
      @(posedge clk);
      if (!mstall) begin m_wb = m_mem; m_mem = m_ex; m_ex = nx; end
      @(negedge clk);
      instr = ins; valid = v; flush = f; mstall = ms;
      #1;
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; instr = ADD_3_1_2; valid = 1'b1; flush = 1'b0; mstall = 1'b0;
      m_ex = '0; m_mem = '0; m_wb = '0;
      #12;
      n_chk++; if ({ex_valid, mem_valid, wb_valid} !== 3'b0) begin n_fail++; $display("FAIL reset_valids got %b want 000", {ex_valid, mem_valid, wb_valid}); end
      n_chk++; if ({ex_ctrl, mem_ctrl, wb_ctrl} !== 33'h0) begin n_fail++; $display("FAIL reset_ctrls got %h want 0", {ex_ctrl, mem_ctrl, wb_ctrl}); end
      n_chk++; if ({ex_rd, mem_rd, wb_rd} !== 15'h0) begin n_fail++; $display("FAIL reset_rds got %h want 0", {ex_rd, mem_rd, wb_rd}); end
      n_chk++; if ({stall, fwd_a, fwd_b, illegal} !== 6'h0) begin n_fail++; $display("FAIL reset_comb got %b want 000000", {stall, fwd_a, fwd_b, illegal}); end
      @(negedge clk);
      rst_n = 1'b1; valid = 1'b0; instr = 32'h0;
      #1;
   endtask

   task automatic test_basic();
      step(ADD_3_1_2, 1'b1, 1'b0, 1'b0);
      step(32'h0, 1'b0, 1'b0, 1'b0);
      n_chk++; if ({ex_valid, ex_ctrl, ex_rd} !== {1'b1, R_C, 5'd3}) begin n_fail++; $display("FAIL basic_ex got %b/%h/%0d want 1/%h/3", ex_valid, ex_ctrl, ex_rd, R_C); end
      idle(2);
      n_chk++; if ({wb_valid, wb_rd} !== {1'b1, 5'd3}) begin n_fail++; $display("FAIL basic_wb got %b/%0d want 1/3", wb_valid, wb_rd); end
   endtask

   task automatic test_load_use();
      idle(3);
      step(LW_5_1, 1'b1, 1'b0, 1'b0);
      step(ADD_6_5_2, 1'b1, 1'b0, 1'b0);
      n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b want 1", stall); end
      step(ADD_6_5_2, 1'b1, 1'b0, 1'b0);
      n_chk++; if ({ex_valid, stall} !== 2'b00) begin n_fail++; $display("FAIL lu_bubble got %b want 00", {ex_valid, stall}); end
      step(32'h0, 1'b0, 1'b0, 1'b0);
      n_chk++; if ({ex_rd, fwd_a, fwd_b} !== {5'd6, 2'b01, 2'b00}) begin n_fail++; $display("FAIL lu_fwd got rd%0d a%b b%b want rd6 a01 b00", ex_rd, fwd_a, fwd_b); end
   endtask

   task automatic test_forward();
      idle(3);
      step(ADD_5_1_2, 1'b1, 1'b0, 1'b0);
      step(SUB_7_5_5, 1'b1, 1'b0, 1'b0);
      step(32'h0, 1'b0, 1'b0, 1'b0);
      n_chk++; if ({fwd_a, fwd_b} !== 4'b1010) begin n_fail++; $display("FAIL fwd_mem got %b want 1010", {fwd_a, fwd_b}); end
      idle(3);
      step(ADD_0_1_2, 1'b1, 1'b0, 1'b0);
      step(SUB_7_0_0, 1'b1, 1'b0, 1'b0);
      step(32'h0, 1'b0, 1'b0, 1'b0);
      n_chk++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL fwd_x0 got %b want 0000", {fwd_a, fwd_b}); end
   endtask

   task automatic test_flush_stall();
      idle(3);
      step(BEQ_1_2, 1'b1, 1'b0, 1'b0);
      step(ADD_3_1_2, 1'b1, 1'b1, 1'b1);
      step(ADD_3_1_2, 1'b1, 1'b1, 1'b1);
      step(ADD_3_1_2, 1'b1, 1'b1, 1'b0);
      n_chk++; if ({ex_valid, ex_ctrl, mem_valid} !== {1'b1, B_C, 1'b0}) begin n_fail++; $display("FAIL frz_ex got %b/%h/%b want 1/%h/0", ex_valid, ex_ctrl, mem_valid, B_C); end
      step(32'h0, 1'b0, 1'b0, 1'b0);
      n_chk++; if ({ex_valid, ex_ctrl} !== 12'h0) begin n_fail++; $display("FAIL flush_bubble got %b/%h want 0/0", ex_valid, ex_ctrl); end
      n_chk++; if ({mem_valid, mem_ctrl} !== {1'b1, B_C}) begin n_fail++; $display("FAIL beq_mem got %b/%h want 1/%h", mem_valid, mem_ctrl, B_C); end
   endtask

   task automatic test_illegal();
      idle(3);
      step(BAD_OP, 1'b1, 1'b0, 1'b0);
      step(32'h0, 1'b0, 1'b0, 1'b0);
      n_chk++; if ({ex_valid, ex_ctrl} !== {1'b1, 11'h0}) begin n_fail++; $display("FAIL ill_ex got %b/%h want 1/0", ex_valid, ex_ctrl); end
`ifdef ILLEGAL_TRAP_EN
      n_chk++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag got %b want 1", illegal); end
`else
      n_chk++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL ill_flag got %b want 0", illegal); end
`endif
      step(32'h0, 1'b0, 1'b0, 1'b0);
      n_chk++; if ({illegal, mem_ctrl} !== 12'h0) begin n_fail++; $display("FAIL ill_mem got %b/%h want 0/0", illegal, mem_ctrl); end
   endtask

   task automatic test_reset_mid();
      step(ADD_3_1_2, 1'b1, 1'b0, 1'b0);
      step(ADD_5_1_2, 1'b1, 1'b0, 1'b0);
      step(ADD_6_5_2, 1'b1, 1'b0, 1'b0);
      step(32'h0, 1'b0, 1'b0, 1'b0);
      n_chk++; if ({ex_valid, mem_valid, wb_valid} !== 3'b111) begin n_fail++; $display("FAIL mid_live got %b want 111", {ex_valid, mem_valid, wb_valid}); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if ({ex_valid, mem_valid, wb_valid, ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, stall, fwd_a, fwd_b, illegal} !== '0) begin
         n_fail++; $display("FAIL mid_reset got v%b fa%b fb%b want all 0", {ex_valid, mem_valid, wb_valid}, fwd_a, fwd_b);
      end
      m_ex = '0; m_mem = '0; m_wb = '0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_random();
      logic [31:0] ins;
      for (int i = 0; i < 600; i++) begin
         ins = {$urandom_range(0, 1) ? 7'h20 : 7'h00, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                3'($urandom), 5'($urandom_range(0, 3)), OPS[$urandom_range(0, 11)]};
         step(ins, $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, $urandom_range(0, 19) < 3);
         n_chk++; if ({ex_valid, ex_ctrl, ex_rd} !== stage_of(m_ex)) begin n_fail++; $display("FAIL rnd_ex cyc%0d got %h want %h", i, {ex_valid, ex_ctrl, ex_rd}, stage_of(m_ex)); end
         n_chk++; if ({mem_valid, mem_ctrl, mem_rd} !== stage_of(m_mem)) begin n_fail++; $display("FAIL rnd_mem cyc%0d got %h want %h", i, {mem_valid, mem_ctrl, mem_rd}, stage_of(m_mem)); end
         n_chk++; if ({wb_valid, wb_ctrl, wb_rd} !== stage_of(m_wb)) begin n_fail++; $display("FAIL rnd_wb cyc%0d got %h want %h", i, {wb_valid, wb_ctrl, wb_rd}, stage_of(m_wb)); end
         n_chk++; if ({stall, fwd_a, fwd_b, illegal} !== {exp_stall(), exp_fwd(1'b0), exp_fwd(1'b1), exp_ill()}) begin
            n_fail++; $display("FAIL rnd_hazard cyc%0d got %b want %b", i, {stall, fwd_a, fwd_b, illegal}, {exp_stall(), exp_fwd(1'b0), exp_fwd(1'b1), exp_ill()});
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_load_use();
      test_forward();
      test_flush_stall();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
